// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bundle for sync_fifo_prog. The master modport is the
// surrounding logic; the slave modport is the FIFO itself.
interface sync_fifo_prog_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [CNT_W-1:0]      afull_thresh;
  logic [CNT_W-1:0]      aempty_thresh;
  logic                  flag_clr;

  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en, afull_thresh, aempty_thresh, flag_clr,
    input  rd_data, rd_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, afull_thresh, aempty_thresh, flag_clr,
    output rd_data, rd_valid, count, full, empty, almost_full, almost_empty,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO of arbitrary depth with runtime thresholds and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a 1-clock registered read.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic           clk_in,
  input  logic           areset_b,
  sync_fifo_prog_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic w_full;
  logic w_empty;
  logic w_push_ok;
  logic w_pop_ok;
  logic w_ovf_set;
  logic w_udf_set;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  assign w_push_ok = bus.wr_en & ~w_full;
  assign w_pop_ok  = bus.rd_en & ~w_empty;
  assign w_ovf_set = bus.wr_en & w_full;
  assign w_udf_set = bus.rd_en & w_empty;

  // NOTE: storage has no reset; occupancy is tracked by the pointers, so stale
  // words are never observable and the array can map onto plain RAM.
  always_ff @(posedge clk_in) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= bus.wr_data;
  end

  // NOTE: all sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop_ok)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A fresh error wins over a coincident clear so no event is ever lost.
  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)         r_overflow  <= 1'b1;
      else if (bus.flag_clr) r_overflow  <= 1'b0;
      if (w_udf_set)         r_underflow <= 1'b1;
      else if (bus.flag_clr) r_underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign bus.rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.rd_valid = ~w_empty;
`else
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;

  always_ff @(posedge clk_in or negedge areset_b) begin
    if (!areset_b) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_pop_ok;
      if (w_pop_ok) r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
`endif

  assign bus.count        = r_count;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= bus.afull_thresh);
  assign bus.almost_empty = (r_count <= bus.aempty_thresh);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench for sync_fifo_prog: a queue model predicts occupancy, flags
// and read data; a negedge monitor consumes expected reads as the DUT shows them.
module tb_sync_fifo_prog;
  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;

  logic clk_in   = 1'b0;
  logic areset_b = 1'b0;
  always #5 clk_in = ~clk_in;

  sync_fifo_prog_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo_prog #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_in   (clk_in),
    .areset_b (areset_b),
    .bus      (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [DW-1:0] m_q [$];
  rd_exp_t       sb [$];
  logic          m_ovf  = 1'b0;
  logic          m_udf  = 1'b0;
  logic [DW-1:0] m_last = '0;
  int            afth   = 4;
  int            aeth   = 1;
  logic [DW-1:0] seq    = 8'h00;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_status();
    check("count",        32'(bus.count),      32'(m_q.size()));
    check("full",         32'(bus.full),       32'(m_q.size() == DEPTH));
    check("empty",        32'(bus.empty),      32'(m_q.size() == 0));
    check("almost_full",  32'(bus.almost_full),  32'(m_q.size() >= afth));
    check("almost_empty", 32'(bus.almost_empty), 32'(m_q.size() <= aeth));
    check("overflow",     32'(bus.overflow),   32'(m_ovf));
    check("underflow",    32'(bus.underflow),  32'(m_udf));
  endtask

  task automatic set_thresh(input int af, input int ae);
    afth = af;
    aeth = ae;
    bus.afull_thresh  = CNT_W'(af);
    bus.aempty_thresh = CNT_W'(ae);
  endtask

  // One clock of stimulus; the model decides from pre-edge occupancy and is
  // updated after the edge so the monitor always sees it aligned with the DUT.
  task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
    int      sz;
    logic    push_ok, pop_ok, set_o, set_u;
    rd_exp_t e;
    int      due;
    bus.wr_en    = wr;
    bus.wr_data  = d;
    bus.rd_en    = rd;
    bus.flag_clr = clr;
    sz      = m_q.size();
    push_ok = wr && (sz < DEPTH);
    pop_ok  = rd && (sz > 0);
    set_o   = wr && (sz == DEPTH);
    set_u   = rd && (sz == 0);
    due     = cyc + 1;
    @(posedge clk_in);
    #1;
    m_ovf = set_o | (m_ovf & ~clr);
    m_udf = set_u | (m_udf & ~clr);
    if (pop_ok) begin
      e.data = m_q.pop_front();
      e.due  = due;
`ifndef SYNC_FIFO_FWFT_EN
      sb.push_back(e);
`endif
    end
    if (push_ok) m_q.push_back(d);
    bus.wr_en    = 1'b0;
    bus.rd_en    = 1'b0;
    bus.flag_clr = 1'b0;
    check_status();
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, seq, 1'b0, 1'b0);
      seq++;
    end
  endtask

  task automatic pop(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic model_reset();
    m_q.delete();
    sb.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_last = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_valid", 32'(bus.rd_valid), 32'(0));
    check("rst_rd_data",  32'(bus.rd_data),  32'(0));
    check_status();
  endtask

  // Monitor: every negedge out of reset, compare the read port to the scoreboard.
  always @(negedge clk_in) begin
    if (areset_b) begin
`ifndef SYNC_FIFO_FWFT_EN
      logic    exp_valid;
      rd_exp_t e;
      exp_valid = (sb.size() > 0) && (sb[0].due <= cyc);
      check("rd_valid", 32'(bus.rd_valid), 32'(exp_valid));
      if (exp_valid) begin
        e = sb.pop_front();
        check("rd_data", 32'(bus.rd_data), 32'(e.data));
        check("rd_latency", 32'(cyc), 32'(e.due));
        m_last = e.data;
      end else begin
        check("rd_data_hold", 32'(bus.rd_data), 32'(m_last));
      end
`else
      check("fwft_valid", 32'(bus.rd_valid), 32'(m_q.size() > 0));
      check("fwft_data",  32'(bus.rd_data),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'(0));
`endif
    end
  end

  initial begin
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.rd_en    = 1'b0;
    bus.flag_clr = 1'b0;
    set_thresh(4, 1);
    #2;
    check_reset_outputs();
    #15 areset_b = 1'b1;
    @(posedge clk_in);
    #1;

    // Fill with A0..A4, then one push too many.
    seq = 8'hA0;
    push(6);
    // Drain in order, then one pop too many.
    pop(6);
    // Flag clear alone, then clear coinciding with a rejected push.
    step(1'b0, '0, 1'b0, 1'b1);
    push(5);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    pop(5);

    // Pointer wrap across the non-power-of-two boundary.
    seq = 8'h10;
    for (int r = 0; r < 4; r++) begin
      push(3);
      pop(3);
    end

    // Simultaneous push/pop at mid, full and empty occupancy.
    push(2);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, seq, 1'b1, 1'b0);
      seq++;
    end
    push(3);
    step(1'b1, seq, 1'b1, 1'b0);
    seq++;
    pop(4);
    step(1'b1, seq, 1'b1, 1'b0);
    seq++;
    pop(1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic with runtime threshold changes checked in-cycle.
    for (int i = 0; i < 600; i++) begin
      logic wr, rd, clr;
      if (i % 40 == 0) begin
        set_thresh(1 + int'($urandom % DEPTH), int'($urandom % DEPTH));
        #1;
        check_status();
      end
      wr  = (i % 200 < 100) ? ($urandom % 4 != 0) : ($urandom % 4 == 0);
      rd  = (i % 200 < 100) ? ($urandom % 3 == 0) : ($urandom % 4 != 0);
      clr = ($urandom % 16 == 0);
      step(wr, DW'($urandom), rd, clr);
    end

    // Asynchronous reset at count 3 with a read in flight.
    set_thresh(4, 1);
    pop(DEPTH);
    push(4);
    step(1'b0, '0, 1'b1, 1'b0);
    areset_b = 1'b0;
    model_reset();
    #1;
    check_reset_outputs();
    @(posedge clk_in);
    #2 areset_b = 1'b1;
    @(posedge clk_in);
    #1;
    check_status();

    // Recovery after reset.
    seq = 8'h55;
    push(2);
    pop(3);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
